// File: rtl/uart_mem_bridge.sv
// UART byte-stream to data-memory initiator: 'W' frames write a word, 'R' frames read one back over tx.
// Define BRIDGE_WRITE_ACK_EN to answer each completed write with a single 0x4B byte.
module uart_mem_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data_in,
  input  logic                  rx_valid_in,
  output logic [7:0]            tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_write_data_out,
  output logic                  mem_write_en_out,
  output logic                  mem_read_en_out,
  input  logic [DATA_WIDTH-1:0] mem_read_data_in,
  output logic                  busy_out,
  output logic                  err_out
);

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;
  // Counter only has to hold TIMEOUT_CYCLES-1; expiry is detected on that value.
  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, READ, SEND, ACK} state_t;

  state_t                  state;
  logic                    is_wr;
  logic [1:0]              cnt;
  logic [TW-1:0]           tmo;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    tmo_hit;

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo == TMO_LAST) && !rx_valid_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      is_wr              <= 1'b0;
      cnt                <= '0;
      tmo                <= '0;
      rd_word            <= '0;
      tx_data_out        <= '0;
      tx_valid_out       <= 1'b0;
      mem_addr_out       <= '0;
      mem_write_data_out <= '0;
      mem_write_en_out   <= 1'b0;
      mem_read_en_out    <= 1'b0;
      busy_out           <= 1'b0;
      err_out            <= 1'b0;
    end else begin
      err_out          <= 1'b0;
      mem_write_en_out <= 1'b0;
      mem_read_en_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid_in) begin
            if (rx_data_in == CMD_WR || rx_data_in == CMD_RD) begin
              is_wr    <= (rx_data_in == CMD_WR);
              tmo      <= '0;
              busy_out <= 1'b1;
              state    <= GET_ADDR;
            end else begin
              err_out <= 1'b1;
            end
          end
        end
        GET_ADDR: begin
          if (rx_valid_in) begin
            mem_addr_out <= {rx_data_in[ADDR_WIDTH-1:2], 2'b00};
            tmo          <= '0;
            cnt          <= '0;
            if (is_wr) begin
              state <= GET_DATA;
            end else begin
              mem_read_en_out <= 1'b1;
              state           <= READ;
            end
          end else if (tmo_hit) begin
            err_out  <= 1'b1;
            tmo      <= '0;
            busy_out <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_valid_in) begin
            mem_write_data_out[{cnt, 3'b000} +: 8] <= rx_data_in;
            cnt <= cnt + 2'd1;
            tmo <= '0;
            if (cnt == 2'd3) begin
              mem_write_en_out <= 1'b1;
              state            <= WRITE;
            end
          end else if (tmo_hit) begin
            err_out  <= 1'b1;
            tmo      <= '0;
            busy_out <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WRITE: begin
`ifdef BRIDGE_WRITE_ACK_EN
          tx_data_out  <= ACK_BYTE;
          tx_valid_out <= 1'b1;
          state        <= ACK;
`else
          busy_out <= 1'b0;
          state    <= IDLE;
`endif
        end
        READ: begin
          // Read data is only valid during the strobe cycle, so capture it here.
          rd_word      <= mem_read_data_in;
          tx_data_out  <= mem_read_data_in[7:0];
          tx_valid_out <= 1'b1;
          cnt          <= '0;
          state        <= SEND;
        end
        SEND: begin
          if (tx_ready_in) begin
            if (cnt == 2'd3) begin
              tx_valid_out <= 1'b0;
              tx_data_out  <= '0;
              busy_out     <= 1'b0;
              state        <= IDLE;
            end else begin
              cnt         <= cnt + 2'd1;
              tx_data_out <= rd_word[{cnt + 2'd1, 3'b000} +: 8];
            end
          end
        end
        ACK: begin
          if (tx_ready_in) begin
            tx_valid_out <= 1'b0;
            tx_data_out  <= '0;
            busy_out     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
      if (rx_valid_in && (state inside {WRITE, READ, SEND, ACK}))
        err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed and randomized bench for uart_mem_bridge against a word-array memory reference.
module tb_uart_mem_bridge;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic          mem_re;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem  [0:15];
  logic [31:0] ref_mem [0:15];
  logic [7:0]  tx_log  [0:255];
  int wr_count = 0, rd_count = 0, both_count = 0, err_count = 0, tx_n = 0;

  uart_mem_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data_in(rx_data), .rx_valid_in(rx_valid),
    .tx_data_out(tx_data), .tx_valid_out(tx_valid), .tx_ready_in(tx_ready),
    .mem_addr_out(mem_addr), .mem_write_data_out(mem_wdata),
    .mem_write_en_out(mem_we), .mem_read_en_out(mem_re),
    .mem_read_data_in(mem_rdata), .busy_out(busy), .err_out(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory seen by the DUT; garbage outside the read strobe exposes mistimed capture.
  assign mem_rdata = mem_re ? tb_mem[mem_addr[5:2]] : 32'hA5A5_0F0F;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
    end else if (mem_we) begin
      tb_mem[mem_addr[5:2]] <= mem_wdata;
    end
    if (mem_we) wr_count <= wr_count + 1;
    if (mem_re) rd_count <= rd_count + 1;
    if (mem_we && mem_re) both_count <= both_count + 1;
    if (err) err_count <= err_count + 1;
    if (tx_valid && tx_ready) begin
      tx_log[tx_n[7:0]] <= tx_data;
      tx_n <= tx_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit stall, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int w0, t0;
    w0 = wr_count;
    t0 = tx_n;
    send_byte(8'h57);
    send_byte(a);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
    check("wr_strobe", 32'(mem_we), 32'd1);
    check("wr_no_read", 32'(mem_re), 32'd0);
    check("wr_addr", 32'(mem_addr), {24'd0, 2'b00, a[5:2], 2'b00});
    check("wr_data", mem_wdata, d);
    ref_mem[a[5:2]] = d;
    @(negedge clk);
    check("wr_pulse_width", 32'(mem_we), 32'd0);
    wait_idle(1'b0, 20);
    check("wr_count", 32'(wr_count), 32'(w0 + 1));
`ifdef BRIDGE_WRITE_ACK_EN
    check("ack_count", 32'(tx_n - t0), 32'd1);
    check("ack_byte", 32'(tx_log[8'(t0)]), 32'h4B);
`else
    check("wr_no_tx", 32'(tx_n - t0), 32'd0);
`endif
  endtask

  task automatic check_read_bytes(input int t0, input logic [31:0] exp);
    check("rd_byte_count", 32'(tx_n - t0), 32'd4);
    for (int k = 0; k < 4; k++)
      check("rd_lane", 32'(tx_log[8'(t0 + k)]), 32'(exp[8*k +: 8]));
  endtask

  task automatic do_read(input logic [7:0] a, input bit stall);
    int t0, r0;
    logic [31:0] exp;
    exp = ref_mem[a[5:2]];
    t0  = tx_n;
    r0  = rd_count;
    send_byte(8'h52);
    send_byte(a);
    check("rd_strobe", 32'(mem_re), 32'd1);
    check("rd_no_write", 32'(mem_we), 32'd0);
    check("rd_addr", 32'(mem_addr), {24'd0, 2'b00, a[5:2], 2'b00});
    wait_idle(stall, 300);
    check("rd_count", 32'(rd_count), 32'(r0 + 1));
    check_read_bytes(t0, exp);
  endtask

  initial begin
    int t0, w0, r0, e0, bad, n;
    logic [7:0]  ra;
    logic [31:0] exp;

    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    do_write(8'h08, 32'hDEAD_BEEF);
    do_read(8'h08, 1'b0);

    // Transmitter stalled: first byte must be held, and rx during SEND is dropped with an error.
    tx_ready = 1'b0;
    t0 = tx_n;
    send_byte(8'h52);
    send_byte(8'h08);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hEF) bad++;
      @(negedge clk);
    end
    check("stall_hold_cycles_bad", 32'(bad), 32'd0);
    check("stall_no_accept", 32'(tx_n - t0), 32'd0);
    send_byte(8'h57);
    check("drop_err", 32'(err), 32'd1);
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_tx_hold", 32'(tx_data), 32'hEF);
    wait_idle(1'b0, 50);
    check_read_bytes(t0, ref_mem[2]);

    // Unknown command byte in IDLE.
    e0 = err_count;
    w0 = wr_count;
    r0 = rd_count;
    send_byte(8'h33);
    check("bad_cmd_err", 32'(err), 32'd1);
    check("bad_cmd_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("bad_cmd_err_pulse", 32'(err), 32'd0);
    check("bad_cmd_err_count", 32'(err_count - e0), 32'd1);
    check("bad_cmd_no_write", 32'(wr_count), 32'(w0));
    check("bad_cmd_no_read", 32'(rd_count), 32'(r0));

    do_write(8'h0B, $urandom);
    do_read(8'h08, 1'b0);

    // Partial frame followed by silence must abort without touching memory.
    w0 = wr_count;
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'h11);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("tmo_no_write", 32'(wr_count), 32'(w0));
    do_write(8'h04, $urandom);
    do_read(8'h04, 1'b1);

    for (int it = 0; it < 8; it++) begin
      do_write(8'($urandom), $urandom);
      do_read(8'($urandom), 1'b1);
    end

    // Reset while lane 2 is on the wire.
    ra  = 8'($urandom);
    exp = ref_mem[ra[5:2]];
    tx_ready = 1'b0;
    send_byte(8'h52);
    send_byte(ra);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    check("lane2_data", 32'(tx_data), 32'(exp[23:16]));
    rst = 1'b1;
    #1;
    check_all_zero("mid_send_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    tx_ready = 1'b1;
    @(negedge clk);
    do_read(8'($urandom), 1'b1);

    check("strobes_never_both", 32'(both_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
